signed_seq_multiplier: RTL and testbench

Sequential signed 8x8 shift-add multiplier for the CSE224 datapath.
- Sits directly downstream of the two's-complement negation stage and uses that operation to form operand magnitudes and to re-apply the sign to the product.
- Operands arrive and results leave over valid/ready handshakes.
- One multiply is in flight at a time. Product is full-width signed with no overflow.

---
 rtl/signed_seq_multiplier.sv | 129 ++++++++++++
 tb/tb_signed_seq_multiplier.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_seq_multiplier.sv
// Sequential signed shift-add multiplier: operands are reduced to magnitudes,
// multiplied over WIDTH cycles, then the sign is re-applied to the product.
module signed_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAG,
    S_MUL,
    S_FIX,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_mag_a;
  logic [WIDTH-1:0]     r_mag_b;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_result_valid;
  logic                 r_busy;
  logic                 r_start_ready;

  logic [WIDTH-1:0]     w_neg_a;
  logic [WIDTH-1:0]     w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_neg;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign w_neg_a   = ~r_a + WIDTH'(1);
  assign w_neg_b   = ~r_b + WIDTH'(1);
  assign w_mag_a   = r_a[WIDTH-1] ? w_neg_a : r_a;
  assign w_mag_b   = r_b[WIDTH-1] ? w_neg_b : r_b;
  assign w_addend  = {{WIDTH{1'b0}}, r_mag_a} << r_count;
  assign w_acc_neg = ~r_acc + (2*WIDTH)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_a            <= '0;
      r_b            <= '0;
      r_mag_a        <= '0;
      r_mag_b        <= '0;
      r_neg          <= 1'b0;
      r_acc          <= '0;
      r_count        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_start_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_a           <= a;
            r_b           <= b;
            r_busy        <= 1'b1;
            r_start_ready <= 1'b0;
            r_state       <= S_MAG;
          end
        end
        S_MAG: begin
          r_mag_a <= w_mag_a;
          r_mag_b <= w_mag_b;
          r_neg   <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_acc   <= '0;
          r_count <= '0;
          r_state <= S_MUL;
        end
        S_MUL: begin
          if (r_mag_b[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_mag_b <= r_mag_b >> 1;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          // Two's-complement of zero is zero, so a zero product never turns negative.
          r_result       <= r_neg ? w_acc_neg : r_acc;
          r_result_valid <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_start_ready  <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign start_ready  = r_start_ready;

  a_busy_state: assert property (@(posedge clk) disable iff (rst) busy == (r_state != S_IDLE));
  a_ready_busy: assert property (@(posedge clk) disable iff (rst) start_ready == !busy);
  a_valid_done: assert property (@(posedge clk) disable iff (rst) result_valid |-> (r_state == S_DONE));

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Scoreboard bench: the driver pushes expected products at each accept, a
// negedge monitor pops and compares at each retire and checks latency/hold.
module tb_signed_seq_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] result;
  logic           result_valid;
  logic           result_ready;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_res = 0;
  int rr_mode = 1;
  logic [15:0] exp_q[$];
  int          acc_q[$];

  signed_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: interpret each byte as a signed integer and multiply.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
    int p;
    sx = x[7] ? int'(x) - 256 : int'(x);
    sy = y[7] ? int'(y) - 256 : int'(y);
    p  = sx * sy;
    return p[15:0];
  endfunction

  // result_ready driver: 0 = held low, 1 = held high, 2 = random per cycle
  initial begin
    result_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       result_ready = 1'b0;
        1:       result_ready = 1'b1;
        default: result_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  logic        prev_valid = 1'b0;
  logic [15:0] prev_result = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      check("busy_vs_start_ready", 32'(busy), 32'(!start_ready));
      if (prev_valid && result_valid)
        check("held_result", 32'(result), 32'(prev_result));
      if (result_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail_now("unexpected_result_valid");
        else check("latency", 32'(cyc - acc_q.pop_front()), 32'd10);
      end
      if (result_valid && result_ready) begin
        n_res++;
        if (exp_q.size() == 0) fail_now("extra_result");
        else check("product", 32'(result), 32'(exp_q.pop_front()));
      end
      prev_valid  = result_valid;
      prev_result = result;
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    a = ta;
    b = tb_v;
    start_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_ready && !rst) begin
        exp_q.push_back(ref_mul(ta, tb_v));
        acc_q.push_back(cyc + 1);
        n_acc++;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
  endtask

  logic [7:0] dir_a[9] = '{8'h03, 8'hFB, 8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'hFE};
  logic [7:0] dir_b[9] = '{8'hFB, 8'h03, 8'h80, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h06};
  logic [15:0] dir_e[9] = '{16'hFFF1, 16'hFFF1, 16'h4000, 16'hC080, 16'h3F01,
                            16'h0000, 16'h0001, 16'hFFFF, 16'hFFF4};

  initial begin
    bit seen;
    rst = 1'b1;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("reset_result", 32'(result), 32'd0);
    check("reset_result_valid", 32'(result_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_start_ready", 32'(start_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed products; the model's answers are cross-checked against hand values
    for (int i = 0; i < 9; i++) begin
      check("model_vs_table", 32'(ref_mul(dir_a[i], dir_b[i])), 32'(dir_e[i]));
      issue(dir_a[i], dir_b[i]);
      wait_drain();
    end

    // Back-pressure with ignored start attempts
    rr_mode = 0;
    issue(8'h12, 8'h34);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      a = 8'h55;
      b = 8'h66;
      start_valid = 1'b1;
      @(negedge clk);
      check("bp_start_ready_low", 32'(start_ready), 32'd0);
      check("bp_valid_held", 32'(result_valid), 32'd1);
      check("bp_result", 32'(result), 32'h03A8);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    rr_mode = 1;
    wait_drain();
    issue(8'h05, 8'hF9);
    wait_drain();

    // Asynchronous reset during the 4th MUL cycle
    issue(8'h40, 8'h33);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_result_valid", 32'(result_valid), 32'd0);
    check("midrst_start_ready", 32'(start_ready), 32'd1);
    exp_q.delete();
    acc_q.delete();
    n_acc--;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(8'hFE, 8'h06);
    wait_drain();

    // Randomised sweep with random consumer stalls
    rr_mode = 2;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue(8'($urandom), 8'($urandom));
    end
    wait_drain();
    repeat (3) @(negedge clk);
    check("result_count", 32'(n_res), 32'(n_acc));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
